// File: rtl/hci_core_rr_arbiter_pkg.sv
// rtl/hci_core_rr_arbiter_pkg.sv - shared constants for the HCI round-robin arbiter slice
// Purpose: field widths of the HCI core interface that are not tied to the data width.
package hci_core_rr_arbiter_pkg;

    localparam int unsigned HCI_AW  = 32;  // address width
    localparam int unsigned HCI_UW  = 2;   // user / r_user width
    localparam int unsigned HCI_BOW = 4;   // byte-offset field width

endpackage

// File: rtl/hci_core_intf.sv
// rtl/hci_core_intf.sv - HCI core request/response interface
// Purpose: one requester<->memory channel.
// Ports: none; signals req/gnt/add/wen/data/be/boffs/user/lrdy (request side),
//        r_data/r_valid/r_opc/r_user (response side).
//        The master modport drives the request side, the slave modport drives responses.
interface hci_core_intf #(
    parameter int unsigned DW = 32
) ();
    import hci_core_rr_arbiter_pkg::*;

    logic                 req;
    logic                 gnt;
    logic [HCI_AW-1:0]    add;
    logic                 wen;
    logic [DW-1:0]        data;
    logic [DW/8-1:0]      be;
    logic [HCI_BOW-1:0]   boffs;
    logic [HCI_UW-1:0]    user;
    logic                 lrdy;
    logic [DW-1:0]        r_data;
    logic                 r_valid;
    logic                 r_opc;
    logic [HCI_UW-1:0]    r_user;

    modport master (
        output req, add, wen, data, be, boffs, user, lrdy,
        input  gnt, r_data, r_valid, r_opc, r_user
    );

    modport slave (
        input  req, add, wen, data, be, boffs, user, lrdy,
        output gnt, r_data, r_valid, r_opc, r_user
    );

endinterface

// File: rtl/hci_core_rr_arbiter_idq.sv
// rtl/hci_core_rr_arbiter_idq.sv - circular FIFO of granted requester indices
// Purpose: remembers which input owns each outstanding response, oldest first.
// Ports: clk_i, rst_ni (async, active-low), clear_i (sync clear),
//        push_i/data_i (write), pop_i (read), data_o (head), full_o, empty_o.
module hci_core_rr_arbiter_idq #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IW    = 2,
    parameter int unsigned CW    = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic [IW-1:0] data_i,
    input  logic          pop_i,
    output logic [IW-1:0] data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rptr_q];

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wrap_inc(wptr_q);
            if (do_pop)  rptr_q <= wrap_inc(rptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/hci_core_rr_arbiter.sv
// rtl/hci_core_rr_arbiter.sv - round-robin arbiter of N HCI requesters onto one memory port
// Purpose: picks one requester per cycle (round-robin, locked while stalled) and routes
//          responses back in grant order using an index queue.
// Ports: clk_i, rst_ni (async, active-low), clear_i (sync clear),
//        tcdm_slave[NB_IN_CHAN] (requesters), tcdm_master (memory side),
//        err_o (sticky: response with nothing outstanding), busy_o (responses outstanding).
module hci_core_rr_arbiter
    import hci_core_rr_arbiter_pkg::*;
#(
    parameter int unsigned NB_IN_CHAN      = 4,
    parameter int unsigned DW              = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    hci_core_intf.slave  tcdm_slave [NB_IN_CHAN-1:0],
    hci_core_intf.master tcdm_master,
    output logic         err_o,
    output logic         busy_o
);

    localparam int unsigned IW   = $clog2(NB_IN_CHAN);
    localparam int unsigned OCCW = $clog2(MAX_OUTSTANDING + 1);

    logic [NB_IN_CHAN-1:0] req, lrdy, gnt, r_valid, wen;
    logic [HCI_AW-1:0]     add   [NB_IN_CHAN];
    logic [DW-1:0]         data  [NB_IN_CHAN];
    logic [DW/8-1:0]       be    [NB_IN_CHAN];
    logic [HCI_BOW-1:0]    boffs [NB_IN_CHAN];
    logic [HCI_UW-1:0]     user  [NB_IN_CHAN];

    logic [IW-1:0] ptr_q, lock_idx_q, win, cand, head, ptr_nxt;
    logic          lock_q, any_req, m_req, push, pop, full, empty, err_q;

    for (genvar i = 0; i < NB_IN_CHAN; i++) begin : g_chan
        assign req[i]   = tcdm_slave[i].req;
        assign add[i]   = tcdm_slave[i].add;
        assign wen[i]   = tcdm_slave[i].wen;
        assign data[i]  = tcdm_slave[i].data;
        assign be[i]    = tcdm_slave[i].be;
        assign boffs[i] = tcdm_slave[i].boffs;
        assign user[i]  = tcdm_slave[i].user;
        assign lrdy[i]  = tcdm_slave[i].lrdy;

        assign gnt[i]     = m_req & tcdm_master.gnt & (win == IW'(i));
        assign r_valid[i] = pop & (head == IW'(i));

        assign tcdm_slave[i].gnt     = gnt[i];
        assign tcdm_slave[i].r_valid = r_valid[i];
        assign tcdm_slave[i].r_data  = tcdm_master.r_data;
        assign tcdm_slave[i].r_opc   = tcdm_master.r_opc;
        assign tcdm_slave[i].r_user  = tcdm_master.r_user;
    end

    // Winner selection. A stalled winner keeps the port while it still requests;
    // otherwise scan downward from the farthest offset so the nearest requester at
    // or after ptr is the last one written.
    always_comb begin
        win     = ptr_q;
        cand    = ptr_q;
        any_req = 1'b0;
        if (lock_q && req[lock_idx_q]) begin
            win     = lock_idx_q;
            any_req = 1'b1;
        end else begin
            for (int off = int'(NB_IN_CHAN) - 1; off >= 0; off--) begin
                cand = IW'((int'(ptr_q) + off) % int'(NB_IN_CHAN));
                if (req[cand]) begin
                    win     = cand;
                    any_req = 1'b1;
                end
            end
        end
    end

    // A full queue blocks new requests even if it drains this cycle, so the
    // forward path never depends on r_valid.
    assign m_req   = any_req & ~full;
    assign push    = m_req & tcdm_master.gnt;
    assign pop     = tcdm_master.r_valid & ~empty;
    assign ptr_nxt = (win == IW'(NB_IN_CHAN - 1)) ? '0 : win + 1'b1;

    assign tcdm_master.req   = m_req;
    assign tcdm_master.add   = add[win];
    assign tcdm_master.wen   = wen[win];
    assign tcdm_master.data  = data[win];
    assign tcdm_master.be    = be[win];
    assign tcdm_master.boffs = boffs[win];
    assign tcdm_master.user  = user[win];
    assign tcdm_master.lrdy  = empty ? 1'b1 : lrdy[head];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else if (clear_i) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (push) ptr_q <= ptr_nxt;
            lock_q     <= m_req & ~tcdm_master.gnt;
            lock_idx_q <= win;
            if (tcdm_master.r_valid && empty) err_q <= 1'b1;
        end
    end

    hci_core_rr_arbiter_idq #(
        .DEPTH (MAX_OUTSTANDING),
        .IW    (IW),
        .CW    (OCCW)
    ) u_idq (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (push),
        .data_i  (win),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign err_o  = err_q;
    assign busy_o = ~empty;

endmodule

// File: tb/tb_hci_core_rr_arbiter.sv
// tb/tb_hci_core_rr_arbiter.sv - self-checking bench for hci_core_rr_arbiter
module tb_hci_core_rr_arbiter;
    import hci_core_rr_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;

    typedef struct {
        bit [3:0] req;
        bit       mg;
        bit       rv;
        bit       clr;
        bit       mreq;
        int       win;
        bit [3:0] gnt;
        bit       busy;
        bit       err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic clear_i = 1'b0;
    logic err_o, busy_o;

    logic [3:0]        s_req = '0;
    logic [3:0]        s_lrdy = 4'b0101;
    logic [3:0]        s_gnt, s_rvalid;
    logic [DW-1:0]     s_rdata [N];
    logic              m_gnt = 1'b0, m_rv = 1'b0;
    logic [DW-1:0]     m_rdata = '0;
    logic              m_req, m_lrdy;
    logic [HCI_AW-1:0] m_add;

    int n_vec = 0;
    int n_err = 0;
    int sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    hci_core_intf #(.DW(DW)) slv [N-1:0] ();
    hci_core_intf #(.DW(DW)) mst ();

    for (genvar g = 0; g < N; g++) begin : g_bind
        assign slv[g].req   = s_req[g];
        assign slv[g].add   = 32'h1000_0000 + 32'(g) * 32'h100;
        assign slv[g].wen   = 1'b0;
        assign slv[g].data  = 32'hA5A5_0000 + 32'(g);
        assign slv[g].be    = '1;
        assign slv[g].boffs = '0;
        assign slv[g].user  = '0;
        assign slv[g].lrdy  = s_lrdy[g];
        assign s_gnt[g]     = slv[g].gnt;
        assign s_rvalid[g]  = slv[g].r_valid;
        assign s_rdata[g]   = slv[g].r_data;
    end

    assign mst.gnt     = m_gnt;
    assign mst.r_valid = m_rv;
    assign mst.r_data  = m_rdata;
    assign mst.r_opc   = 1'b0;
    assign mst.r_user  = '0;
    assign m_req  = mst.req;
    assign m_add  = mst.add;
    assign m_lrdy = mst.lrdy;

    hci_core_rr_arbiter #(.NB_IN_CHAN(N), .DW(DW), .MAX_OUTSTANDING(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .tcdm_slave  (slv),
        .tcdm_master (mst),
        .err_o       (err_o),
        .busy_o      (busy_o)
    );

    function automatic logic [31:0] addr_of(int i);
        return 32'h1000_0000 + 32'(i) * 32'h100;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(bit [3:0] req, bit mg, bit rv, bit clr, bit mreq,
                               int win, bit [3:0] gnt, bit busy, bit err);
        vec_t t;
        t.req = req; t.mg = mg; t.rv = rv; t.clr = clr; t.mreq = mreq;
        t.win = win; t.gnt = gnt; t.busy = busy; t.err = err;
        return t;
    endfunction

    initial begin
        logic [3:0] exp_rv;
        logic       exp_lrdy;
        int         h;

        // full-speed rotation with one-cycle responses
        tbl.push_back(v(4'hF, 1, 0, 0, 1,  0, 4'b0001, 0, 0));
        tbl.push_back(v(4'hF, 1, 1, 0, 1,  1, 4'b0010, 1, 0));
        tbl.push_back(v(4'hF, 1, 1, 0, 1,  2, 4'b0100, 1, 0));
        tbl.push_back(v(4'hF, 1, 1, 0, 1,  3, 4'b1000, 1, 0));
        tbl.push_back(v(4'hF, 1, 1, 0, 1,  0, 4'b0001, 1, 0));
        tbl.push_back(v(4'h0, 1, 1, 0, 0, -1, 4'b0000, 1, 0));
        // inputs 1 and 3, stalled three cycles
        tbl.push_back(v(4'hA, 0, 0, 0, 1,  1, 4'b0000, 0, 0));
        tbl.push_back(v(4'hA, 0, 0, 0, 1,  1, 4'b0000, 0, 0));
        tbl.push_back(v(4'hA, 0, 0, 0, 1,  1, 4'b0000, 0, 0));
        tbl.push_back(v(4'hA, 1, 0, 0, 1,  1, 4'b0010, 0, 0));
        tbl.push_back(v(4'hA, 1, 0, 0, 1,  3, 4'b1000, 1, 0));
        // lock holds input 1 although input 0 sits at the pointer
        tbl.push_back(v(4'h2, 0, 0, 0, 1,  1, 4'b0000, 1, 0));
        tbl.push_back(v(4'h3, 0, 0, 0, 1,  1, 4'b0000, 1, 0));
        // push + pop at occupancy 2
        tbl.push_back(v(4'h3, 1, 1, 0, 1,  1, 4'b0010, 1, 0));
        // fill to 4, blocked even while popping
        tbl.push_back(v(4'hF, 1, 0, 0, 1,  2, 4'b0100, 1, 0));
        tbl.push_back(v(4'hF, 1, 0, 0, 1,  3, 4'b1000, 1, 0));
        tbl.push_back(v(4'hF, 1, 1, 0, 0, -1, 4'b0000, 1, 0));
        tbl.push_back(v(4'hF, 1, 0, 0, 1,  0, 4'b0001, 1, 0));
        tbl.push_back(v(4'hF, 1, 0, 0, 0, -1, 4'b0000, 1, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(v(4'h0, 1, 1, 0, 0, -1, 4'b0000, 1, 0));
        // response with nothing outstanding, then clear
        tbl.push_back(v(4'h0, 1, 1, 0, 0, -1, 4'b0000, 0, 0));
        tbl.push_back(v(4'h0, 0, 0, 0, 0, -1, 4'b0000, 0, 1));
        tbl.push_back(v(4'h0, 0, 0, 1, 0, -1, 4'b0000, 0, 1));
        tbl.push_back(v(4'h0, 0, 0, 0, 0, -1, 4'b0000, 0, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset err", 32'(err_o), 32'd0);
        check("reset gnt", 32'(s_gnt), 32'd0);
        check("reset rvalid", 32'(s_rvalid), 32'd0);
        check("reset mreq", 32'(m_req), 32'd0);
        @(posedge clk); #1 rst_ni = 1'b1;

        foreach (tbl[k]) begin
            @(posedge clk); #1;
            s_req = tbl[k].req; m_gnt = tbl[k].mg; m_rv = tbl[k].rv;
            clear_i = tbl[k].clr; m_rdata = $urandom;
            exp_lrdy = (sb.size() != 0) ? s_lrdy[sb[0]] : 1'b1;
            exp_rv = '0;
            if (tbl[k].rv && sb.size() != 0) exp_rv = 4'(1 << sb.pop_front());
            @(negedge clk);
            check($sformatf("v%0d gnt", k), 32'(s_gnt), 32'(tbl[k].gnt));
            check($sformatf("v%0d mreq", k), 32'(m_req), 32'(tbl[k].mreq));
            if (tbl[k].mreq) check($sformatf("v%0d add", k), m_add, addr_of(tbl[k].win));
            check($sformatf("v%0d rvalid", k), 32'(s_rvalid), 32'(exp_rv));
            check($sformatf("v%0d lrdy", k), 32'(m_lrdy), 32'(exp_lrdy));
            check($sformatf("v%0d busy", k), 32'(busy_o), 32'(tbl[k].busy));
            check($sformatf("v%0d err", k), 32'(err_o), 32'(tbl[k].err));
            check($sformatf("v%0d rdata", k), s_rdata[k % N], m_rdata);
            if (tbl[k].gnt != 0) sb.push_back(tbl[k].win);
            if (tbl[k].clr) sb.delete();
        end

        // three outstanding, then asynchronous reset
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            clear_i = 1'b0; s_req = 4'hF; m_gnt = 1'b1; m_rv = 1'b0;
            @(negedge clk);
            check($sformatf("pre-reset gnt%0d", i), 32'(s_gnt), 32'(1 << i));
            sb.push_back(i);
        end
        @(posedge clk); #1;
        s_req = 4'h0; m_gnt = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        check("async reset busy", 32'(busy_o), 32'd0);
        check("async reset gnt", 32'(s_gnt), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_ni = 1'b1; s_req = 4'b0110; m_gnt = 1'b1;
        @(negedge clk);
        check("post-reset gnt", 32'(s_gnt), 32'b0010);
        check("post-reset add", m_add, addr_of(1));
        sb.push_back(1);
        @(posedge clk); #1;
        s_req = 4'h0; m_rv = 1'b1;
        @(negedge clk);
        h = sb.pop_front();
        check("post-reset rvalid", 32'(s_rvalid), 32'(1 << h));
        @(posedge clk); #1;
        m_rv = 1'b1;
        @(negedge clk);
        check("stale rvalid", 32'(s_rvalid), 32'd0);
        check("stale err pre", 32'(err_o), 32'd0);
        @(posedge clk); #1;
        m_rv = 1'b0;
        @(negedge clk);
        check("stale err", 32'(err_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hci_core_rr_arbiter.md
HCI_CORE_RR_ARBITER -- requirements
Module: hci_core_rr_arbiter

Interface
REQ-001 SHALL have parameter NB_IN_CHAN, default 4, number of requester ports (>=2).
REQ-002 SHALL have parameter DW, default 32, data width of all ports.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, depth of the pending-response ID queue (>=1).
REQ-004 SHALL have port clk_i  input  1  clock, rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clear_i  input  1  synchronous clear of all state.
REQ-007 SHALL have port tcdm_slave  hci_core_intf.slave  [NB_IN_CHAN-1:0]  requester ports.
REQ-008 SHALL have port tcdm_master  hci_core_intf.master  1  shared memory-side port.
REQ-009 SHALL have port err_o  output  1  sticky flag: r_valid received with empty ID queue.
REQ-010 SHALL have port busy_o  output  1  ID queue non-empty.

Function
REQ-011 Winner SHALL be the first requesting input at or after priority pointer ptr, searching upward modulo NB_IN_CHAN.
REQ-012 master.req, add, wen, be, data, boffs, user SHALL equal the winner's fields; master.req=0 when no input requests.
REQ-013 Winner's gnt SHALL equal master.gnt combinationally (zero latency); all other inputs' gnt SHALL be 0.
REQ-014 On master.req & master.gnt with winner k, ptr SHALL become (k+1) mod NB_IN_CHAN next cycle; otherwise ptr SHALL hold.
REQ-015 Lock: if master.req & ~master.gnt, winner k SHALL be registered and SHALL remain winner next cycle regardless of other requests, until granted or k drops req.
REQ-016 On master.req & master.gnt, winner index SHALL be pushed to the ID queue.
REQ-017 On master.r_valid, queue head SHALL be popped and r_valid SHALL be asserted only on the input equal to the head.
REQ-018 r_data, r_opc, r_user SHALL be broadcast unmodified to all inputs; only r_valid is steered.
REQ-019 master.lrdy SHALL equal lrdy of the head input when queue non-empty, else 1.
REQ-020 Queue full: master.req SHALL be forced 0 and all gnt 0, even if a pop occurs in the same cycle.
REQ-021 Simultaneous push and pop on a non-full queue SHALL keep occupancy unchanged and preserve order.
REQ-022 r_valid with empty queue: no input r_valid, queue unchanged, err_o set to 1 next cycle and held.
REQ-023 busy_o SHALL be 1 exactly when queue occupancy > 0 (registered state).

Reset
REQ-024 rst_ni low SHALL asynchronously set ptr=0, lock cleared, queue empty, err_o=0, busy_o=0.
REQ-025 clear_i high SHALL apply the same values synchronously; clear_i has priority over push/pop that cycle.
REQ-026 Responses for requests outstanding at reset/clear SHALL be treated per REQ-022.
REQ-027 After reset, with no requests, all slave gnt and r_valid SHALL be 0.

Structure
REQ-028 Index width ($clog2(NB_IN_CHAN)) and occupancy width SHALL be localparams; no new shared-package typedefs are required.
REQ-029 ID queue SHALL be a sub-module hci_core_rr_arbiter_idq (circular buffer, read/write pointers, occupancy counter, push/pop/full/empty).
REQ-030 Arbitration logic SHALL be purely combinational from ptr, lock and requests; no gnt->req combinational loop.

Verification
REQ-031 All 4 inputs req continuously, master.gnt=1 -> grants in order 0,1,2,3,0; r_valid one cycle later steered to same order.
REQ-032 Inputs 1 and 3 req, master.gnt=0 for 3 cycles, then 1 -> input 1 held as winner throughout, granted in cycle 4; input 3 granted next cycle.
REQ-033 MAX_OUTSTANDING=4, 4 grants with no r_valid -> master.req=0 in cycle 5 despite pending requests; one r_valid -> req re-asserted next cycle.
REQ-034 r_valid with empty queue -> no slave r_valid, err_o=1 next cycle, stays 1 until clear_i.
REQ-035 Push and pop in same cycle at occupancy 2 -> occupancy stays 2, response routed to older ID.
REQ-036 rst_ni asserted with 3 outstanding -> busy_o=0 immediately, ptr=0, next grant to lowest requesting index.
